ieeedrv_sd_arb: RTL
===================

// Module: ieeedrv_sd_arb
// PURPOSE
//  Arbitrates the per-subdrive SD sector requests (lba, blk_cnt, rd, wr) of all drive units onto the
//  single MiSTer HPS block-device port. Sits downstream of the drive units' track loaders; routes
//  sd_ack and write data back to the granted requester. Round-robin; one transfer in flight.
// PARAMETERS
//  NREQ       2   number of requesters (subdrives across all units), 1..8
//  TIMEOUT_W  24  width of ack-watchdog counter (used only with IEEEDRV_SD_TIMEOUT_EN)
// PORTS
//  clk_sys       in   1         system clock
//  reset         in   1         synchronous, active-high
//  req_lba       in   32 x NREQ requested LBA per requester
//  req_blk_cnt   in   6 x NREQ  block count-1 per requester
//  req_rd        in   NREQ      read request, held until req_ack seen
//  req_wr        in   NREQ      write request, held until req_ack seen
//  req_ack       out  NREQ      sd_ack routed to granted requester only
//  req_buff_din  in   8 x NREQ  write data from requester track buffer
//  req_err       out  NREQ      1-cycle pulse: request aborted by watchdog
//  sd_lba        out  32        to HPS
//  sd_blk_cnt    out  6         to HPS
//  sd_rd         out  1         to HPS
//  sd_wr         out  1         to HPS
//  sd_ack        in   1         from HPS
//  sd_buff_din   out  8         to HPS: req_buff_din of granted requester (0 when idle)
//  busy          out  1         transfer granted/in flight
// BEHAVIOUR
//  - Reset: all outputs 0, state WAITLOW, grant pointer = NREQ-1 (first search starts at 0).
//  - States: WAITLOW -> IDLE when sd_ack=0 (guards reset during an HPS transfer).
//    IDLE: scan from ptr+1 wrapping mod NREQ; first requester with rd|wr wins; register grant,
//    ptr<=winner, latch lba/blk_cnt/op, -> ISSUE. sd_rd/sd_wr high the cycle after request seen.
//    ISSUE: hold sd_rd or sd_wr + latched lba/blk_cnt until sd_ack=1 -> XFER.
//      Requester drops both rd and wr before ack: deassert sd_rd/sd_wr next cycle, -> IDLE, no ack.
//    XFER: sd_rd/sd_wr cleared on entry; req_ack[grant]=sd_ack combinationally; request level
//      changes ignored; sd_ack falls -> IDLE (busy=0 from next cycle).
//  - rd and wr both high on one requester: rd served; wr stays pending for a later grant.
//  - sd_lba/sd_blk_cnt stable from ISSUE entry until IDLE; never change while sd_ack=1.
//  - sd_buff_din: mux of req_buff_din[grant], registered-free (combinational); 0 outside ISSUE/XFER.
//  - req_ack bits of non-granted requesters always 0; at most one req_ack bit high.
//  - Back-to-back: same requester may be regranted only if no other requester is pending.
//  - reset mid-transfer: outputs drop to 0 next cycle; WAITLOW until HPS releases sd_ack.
// CONFIGURATION
//  IEEEDRV_SD_TIMEOUT_EN defined: counter cleared on ISSUE entry, counts each ISSUE cycle; on
//    reaching all-ones: drop sd_rd/sd_wr, pulse req_err[grant] 1 cycle, -> IDLE, advance ptr.
//  Not defined: no counter, ISSUE waits indefinitely; req_err tied 0.
// TESTING
//  1 reset; req_rd[0]=1 lba=357 blk=0x1F -> next cycle sd_rd=1, sd_lba=357; ack 64 cycles ->
//    req_ack[0] mirrors, req_ack[1]=0; busy falls cycle after ack low.
//  2 req_rd[0],req_rd[1] same cycle (NREQ=2) -> grant 0 first, then 1; next round starts at 0.
//  3 req_wr[1], lba=1102: during XFER drive req_buff_din[1]=A5 -> sd_buff_din=A5; req_buff_din[0]
//    changes have no effect.
//  4 reset asserted with sd_ack=1 mid-XFER -> outputs 0; new req_rd held until sd_ack low, then sd_rd.
//  5 req_rd[0] raised then dropped before ack -> sd_rd low next cycle, no req_ack, req_rd[1] served.
//  6 TIMEOUT_EN, TIMEOUT_W=4, ack never rises -> after 15 ISSUE cycles req_err[0] 1-cycle pulse, sd_rd=0.

Source files
------------

// File: rtl/ieeedrv_sd_arb.sv
// Round-robin arbiter of per-subdrive SD sector requests onto the single HPS block-device port.
// Optional ack watchdog enabled by defining IEEEDRV_SD_TIMEOUT_EN.
`timescale 1ns / 1ps
module ieeedrv_sd_arb #(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned TIMEOUT_W = 24
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [NREQ-1:0][31:0] req_lba_i,
  input  logic [NREQ-1:0][5:0]  req_blk_cnt_i,
  input  logic [NREQ-1:0]       req_rd_i,
  input  logic [NREQ-1:0]       req_wr_i,
  output logic [NREQ-1:0]       req_ack_o,
  input  logic [NREQ-1:0][7:0]  req_buff_din_i,
  output logic [NREQ-1:0]       req_err_o,
  output logic [31:0]           sd_lba_o,
  output logic [5:0]            sd_blk_cnt_o,
  output logic                  sd_rd_o,
  output logic                  sd_wr_o,
  input  logic                  sd_ack_i,
  output logic [7:0]            sd_buff_din_o,
  output logic                  busy_o
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 1 || NREQ > 8 || TIMEOUT_W < 1) begin : gen_param_err
    $error("ieeedrv_sd_arb: NREQ must be 1..8 and TIMEOUT_W at least 1");
  end

  typedef enum logic [1:0] {StWaitLow, StIdle, StIssue, StXfer} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [PtrW-1:0]   grant_q, grant_d;
  logic              op_rd_q, op_rd_d;
  logic [31:0]       lba_q, lba_d;
  logic [5:0]        blk_q, blk_d;
  logic              found;
  logic [PtrW-1:0]   winner;
  logic              tmo_hit;

`ifdef IEEEDRV_SD_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;

  assign tmo_hit = (state_q == StIssue) && (&tmo_q);

  // Held at zero while idle so every ISSUE entry starts a fresh count.
  always_comb begin
    tmo_d = tmo_q;
    if (state_q == StIdle) begin
      tmo_d = '0;
    end else if (state_q == StIssue) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    int unsigned idx;
    idx    = 0;
    found  = 1'b0;
    winner = ptr_q;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = (32'(ptr_q) + i) % NREQ;
      if (!found && (req_rd_i[PtrW'(idx)] || req_wr_i[PtrW'(idx)])) begin
        found  = 1'b1;
        winner = PtrW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    op_rd_d = op_rd_q;
    lba_d   = lba_q;
    blk_d   = blk_q;
    unique case (state_q)
      StWaitLow: begin
        if (!sd_ack_i) state_d = StIdle;
      end
      StIdle: begin
        if (found) begin
          state_d = StIssue;
          grant_d = winner;
          ptr_d   = winner;
          op_rd_d = req_rd_i[winner];
          lba_d   = req_lba_i[winner];
          blk_d   = req_blk_cnt_i[winner];
        end
      end
      StIssue: begin
        if (tmo_hit) begin
          state_d = StIdle;
        end else if (sd_ack_i) begin
          state_d = StXfer;
        end else if (!(req_rd_i[grant_q] || req_wr_i[grant_q])) begin
          state_d = StIdle;
        end
      end
      StXfer: begin
        if (!sd_ack_i) state_d = StIdle;
      end
      default: state_d = StWaitLow;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= StWaitLow;
      ptr_q   <= PtrW'(NREQ - 1);
      grant_q <= '0;
      op_rd_q <= 1'b0;
      lba_q   <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      op_rd_q <= op_rd_d;
      lba_q   <= lba_d;
      blk_q   <= blk_d;
    end
  end

  always_comb begin
    req_ack_o     = '0;
    req_err_o     = '0;
    sd_buff_din_o = '0;
    busy_o        = (state_q == StIssue) || (state_q == StXfer);
    sd_rd_o       = (state_q == StIssue) && op_rd_q && !tmo_hit;
    sd_wr_o       = (state_q == StIssue) && !op_rd_q && !tmo_hit;
    sd_lba_o      = lba_q;
    sd_blk_cnt_o  = blk_q;
    if (((state_q == StIssue) && !tmo_hit) || (state_q == StXfer)) begin
      req_ack_o[grant_q] = sd_ack_i;
    end
    if (tmo_hit) begin
      req_err_o[grant_q] = 1'b1;
    end
    if (busy_o) begin
      sd_buff_din_o = req_buff_din_i[grant_q];
    end
  end

endmodule
